// File: rtl/fc_act_loader.sv
// fc_act_loader: packs an activation stream into a frozen vector for a
// combinational FC layer, waits out its settle window, then holds the result.
module fc_act_loader #(
  parameter int WIDTH  = 8,
  parameter int IN     = 84,
  parameter int ZW     = 22,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] x [0:IN-1],
  input  logic [ZW-1:0]    layer_z,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ZW-1:0]    m_data,
  output logic             err_len
);
  localparam int IW = (IN > 1) ? $clog2(IN) : 1;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(IN - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE);

  typedef enum logic [1:0] {
    LOAD,
    SETL,
    OUT
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] x_q [IN];
  logic [ZW-1:0]    data_q;
  logic             valid_q;
  logic             err_q;
  logic             s_fire;
  logic             at_end;
  logic             frame_end;
  logic             len_bad;

  assign s_ready   = rst_n && (state_q == LOAD);
  assign s_fire    = s_valid && s_ready;
  assign at_end    = (idx_q == LAST_IDX);
  assign frame_end = s_fire && (s_last || at_end);
  // A frame is well formed only when s_last lands on the final slot.
  assign len_bad   = frame_end && (s_last != at_end);
  assign idx_d     = frame_end ? '0 : idx_q + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < IN; i++) x_q[i] <= '0;
    end else begin
      if (len_bad) err_q <= 1'b1;
      unique case (state_q)
        LOAD: begin
          if (s_fire) begin
            x_q[idx_q] <= s_data;
            idx_q      <= idx_d;
            if (frame_end) begin
              state_q <= SETL;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        SETL: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            data_q  <= layer_z;
            valid_q <= 1'b1;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (m_ready) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            state_q <= LOAD;
            for (int i = 0; i < IN; i++) x_q[i] <= '0;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign x       = x_q;
  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign err_len = err_q;

endmodule

// File: tb/tb_fc_act_loader.sv
// tb_fc_act_loader: directed frames against fc_act_loader with a
// one-cycle-latency behavioural layer producing layer_z.
module tb_fc_act_loader;
  localparam int WIDTH = 8;
  localparam int IN    = 84;
  localparam int ZW    = 22;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic [WIDTH-1:0] x [0:IN-1];
  logic [ZW-1:0]    layer_z = '0;
  logic             m_valid;
  logic             m_ready;
  logic [ZW-1:0]    m_data;
  logic             err_len;

  logic [WIDTH-1:0] ex [IN];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  fc_act_loader #(
    .WIDTH(WIDTH), .IN(IN), .ZW(ZW), .SETTLE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .x(x), .layer_z(layer_z),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .err_len(err_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wgt(input int i);
    return (i % 5) - 1;
  endfunction

  // Layer path: ReLU(sum w*x), visible one edge after x settles
  function automatic logic [ZW-1:0] layer_f();
    int s = 0;
    for (int i = 0; i < IN; i++) s += wgt(i) * int'($signed(x[i]));
    return (s < 0) ? '0 : ZW'(s);
  endfunction

  always @(posedge clk) layer_z <= layer_f();

  function automatic int zexp();
    int s = 0;
    for (int i = 0; i < IN; i++) s += wgt(i) * int'($signed(ex[i]));
    return (s < 0) ? 0 : s;
  endfunction

  function automatic int xbad();
    int n = 0;
    for (int i = 0; i < IN; i++) if (x[i] !== ex[i]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_ex();
    for (int i = 0; i < IN; i++) ex[i] = '0;
  endtask

  task automatic send(input logic [7:0] d, input logic l, output int t);
    int g = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("send_timeout", 0, 1);
    @(negedge clk);
    t = cyc;
  endtask

  task automatic check_result(input string tag, input int t0,
                              input int exp_err);
    int g = 0;
    while (!m_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_lat"}, cyc - t0, 2);
    chk({tag, "_mdata"}, int'(m_data), zexp());
    chk({tag, "_err"}, int'(err_len), exp_err);
    chk({tag, "_x"}, xbad(), 0);
    chk({tag, "_sready"}, int'(s_ready), 0);
  endtask

  task automatic handshake(input string tag);
    clr_ex();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk({tag, "_hs_mvalid"}, int'(m_valid), 0);
    chk({tag, "_hs_xclr"}, xbad(), 0);
    chk({tag, "_hs_sready"}, int'(s_ready), 1);
  endtask

  task automatic ramp(input bit bub, output int t);
    for (int i = 0; i < IN; i++) begin
      if (bub && $urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      send(8'(i + 1), i == IN - 1, t);
      ex[i] = 8'(i + 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t;
    int bv, bd, br, bx;
    logic [ZW-1:0] d0;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b0;
    clr_ex();
    repeat (2) @(negedge clk);
    chk("rst_sready", int'(s_ready), 0);
    chk("rst_mvalid", int'(m_valid), 0);
    chk("rst_mdata", int'(m_data), 0);
    chk("rst_err", int'(err_len), 0);
    chk("rst_x", xbad(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_sready", int'(s_ready), 1);

    ramp(1'b0, t);
    check_result("full", t, 0);

    // Backpressure with a pending beat on the input
    s_valid = 1'b1;
    s_data = 8'h55;
    d0 = m_data;
    bv = 0; bd = 0; br = 0; bx = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_valid !== 1'b1) bv++;
      if (m_data !== d0) bd++;
      if (s_ready !== 1'b0) br++;
      if (xbad() != 0) bx++;
    end
    chk("bp_mvalid", bv, 0);
    chk("bp_mdata", bd, 0);
    chk("bp_sready", br, 0);
    chk("bp_x", bx, 0);
    s_valid = 1'b0;
    handshake("bp");

    for (int i = 0; i < 10; i++) begin
      send(8'h7F, i == 9, t);
      ex[i] = 8'h7F;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    check_result("short", t, 1);
    handshake("short");

    do_reset();
    chk("rst2_err", int'(err_len), 0);

    for (int i = 0; i < IN; i++) begin
      send(8'(i + 1), 1'b0, t);
      ex[i] = 8'(i + 1);
    end
    s_data = 8'd85;
    check_result("long1", t, 1);
    handshake("long1");
    for (int i = 0; i < 6; i++) begin
      send(8'(85 + i), i == 5, t);
      ex[i] = 8'(85 + i);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    check_result("long2", t, 1);
    handshake("long2");

    ramp(1'b1, t);
    check_result("bubble", t, 1);
    handshake("bubble");

    do_reset();
    for (int i = 0; i < 40; i++) send(8'(i + 1), 1'b0, t);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    clr_ex();
    chk("midrst_x", xbad(), 0);
    chk("midrst_mvalid", int'(m_valid), 0);
    chk("midrst_err", int'(err_len), 0);
    chk("midrst_sready", int'(s_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ramp(1'b0, t);
    check_result("after_rst", t, 0);
    handshake("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
